// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite slave memory: response codes,
// channel FSM states and the byte-address to word-index decode.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_HAVE_A = 2'b01,
        WR_HAVE_D = 2'b10,
        WR_RESP   = 2'b11
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // Decoded address: below_base flags addresses under the memory window,
    // idx is the word offset from the base (low byte-offset bits dropped).
    typedef struct packed {
        logic        below_base;
        logic [63:0] idx;
    } addr_dec_t;

    function automatic addr_dec_t addr_to_idx(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int unsigned byte_shift);
        addr_dec_t dec;
        dec.below_base = (addr < base);
        dec.idx        = (addr - base) >> byte_shift;
        return dec;
    endfunction

endpackage

// File: rtl/axi4_lite_lfsr_stall.sv
// Pseudo-random ready-stall generator: 16-bit Fibonacci LFSR
// (x^16 + x^14 + x^13 + x^11) stepping every cycle; the low three bits
// are handed out as stall masks for awready, wready and arready.
module axi4_lite_lfsr_stall #(
    parameter logic [15:0] P_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       arst_n,
    output logic [2:0] stall_mask
);

    logic [15:0] lfsr;
    logic        feedback;

    assign feedback   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign stall_mask = lfsr[2:0];

    // Shift register restarts from the seed on every reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr <= P_SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory: word-addressed RAM behind independent write and
// read channel FSMs, byte strobes, AW/W in any order, SLVERR outside the
// window. Define AXI4L_MEM_STALL_EN to mask the readys with an LFSR.
module axi4_lite_slave_mem
    import axi4_lite_pkg::*;
#(
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_ADDR_WIDTH = 32,
    parameter int                      P_DEPTH      = 256,
    parameter logic [P_ADDR_WIDTH-1:0] P_BASE_ADDR  = '0,
    parameter logic [15:0]             P_LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [P_ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [P_DATA_WIDTH-1:0]   wdata,
    input  logic [P_DATA_WIDTH/8-1:0] wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [P_ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [P_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp
);

    localparam int unsigned STRB_W     = P_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
    localparam int unsigned IDX_W      = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic       init_done;
    logic [2:0] stall_mask;

    logic aw_hs, w_hs, ar_hs;
    logic commit_en;

    logic [P_ADDR_WIDTH-1:0] aw_addr_q;
    logic [P_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]       w_strb_q;

    logic [P_ADDR_WIDTH-1:0] commit_addr;
    logic [P_DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]       commit_strb;

    addr_dec_t          wr_dec, rd_dec;
    logic               wr_in_range, rd_in_range;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [P_DATA_WIDTH-1:0] rd_word;

    axi_resp_e               bresp_q, rresp_q;
    logic [P_DATA_WIDTH-1:0] rdata_q;

    logic unused_cfg;
    assign unused_cfg = ^{awprot, arprot, P_LFSR_SEED};

`ifdef AXI4L_MEM_STALL_EN
    axi4_lite_lfsr_stall #(
        .P_SEED     (P_LFSR_SEED)
    ) u_stall (
        .clk        (clk),
        .arst_n     (arst_n),
        .stall_mask (stall_mask)
    );
`else
    assign stall_mask = 3'b000;
`endif

    // Readys stay low for the first cycle after reset release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Write channel state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Write channel next state and ready/valid decode; whichever of AW/W is missing is still accepted
    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                awready = init_done && !stall_mask[0];
                wready  = init_done && !stall_mask[1];
                if (awvalid && awready && wvalid && wready) begin
                    wr_next = WR_RESP;
                end else if (awvalid && awready) begin
                    wr_next = WR_HAVE_A;
                end else if (wvalid && wready) begin
                    wr_next = WR_HAVE_D;
                end
            end
            WR_HAVE_A: begin
                wready = init_done && !stall_mask[1];
                if (wvalid && wready) begin
                    wr_next = WR_RESP;
                end
            end
            WR_HAVE_D: begin
                awready = init_done && !stall_mask[0];
                if (awvalid && awready) begin
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign commit_en = (wr_next == WR_RESP) && (wr_state != WR_RESP);

    // A beat arriving now is used directly; a beat accepted earlier comes from its holding register
    assign commit_addr = (wr_state == WR_HAVE_A) ? aw_addr_q : awaddr;
    assign commit_data = (wr_state == WR_HAVE_D) ? w_data_q  : wdata;
    assign commit_strb = (wr_state == WR_HAVE_D) ? w_strb_q  : wstrb;

    assign wr_dec      = addr_to_idx(64'(commit_addr), 64'(P_BASE_ADDR), BYTE_SHIFT);
    assign wr_in_range = !wr_dec.below_base && (wr_dec.idx < 64'(P_DEPTH));
    assign wr_idx      = wr_dec.idx[IDX_W-1:0];

    // Hold early AW/W beats and register the write response at commit
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit_en) begin
                bresp_q <= wr_in_range ? OKAY : SLVERR;
            end
        end
    end

    assign bresp = bresp_q;

    // Read channel state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    // Read channel next state and ready/valid decode; at most one read every two cycles
    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                arready = init_done && !stall_mask[2];
                if (arvalid && arready) begin
                    rd_next = RD_RESP;
                end
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    rd_next = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign ar_hs       = arvalid && arready;
    assign rd_dec      = addr_to_idx(64'(araddr), 64'(P_BASE_ADDR), BYTE_SHIFT);
    assign rd_in_range = !rd_dec.below_base && (rd_dec.idx < 64'(P_DEPTH));
    assign rd_idx      = rd_dec.idx[IDX_W-1:0];

    // Capture read data on AR; a same-edge write to the word is not yet visible
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_in_range ? rd_word : '0;
            rresp_q <= rd_in_range ? OKAY : SLVERR;
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;

    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        logic [7:0] bank [P_DEPTH];

        // Byte lane write, only strobed lanes of in-range commits
        always_ff @(posedge clk) begin
            if (commit_en && wr_in_range && commit_strb[b]) begin
                bank[wr_idx] <= commit_data[8*b +: 8];
            end
        end

        assign rd_word[8*b +: 8] = bank[rd_idx];
    end

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Self-checking bench for axi4_lite_slave_mem (default build, stalls off).
// Directed steps followed by randomized writes/reads checked against a
// byte-level reference memory kept in the bench.
module tb_axi4_lite_slave_mem;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot, arprot;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem   [DEPTH];
    logic [3:0]  ref_known [DEPTH];

    axi4_lite_slave_mem #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW),
        .P_DEPTH      (DEPTH),
        .P_BASE_ADDR  (BASE),
        .P_LFSR_SEED  (16'hACE1)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] addr);
        longint unsigned a = longint'(addr);
        longint unsigned b = longint'(BASE);
        return (a >= b) && ((a - b) / 4 < DEPTH);
    endfunction

    function automatic int ref_index(input logic [31:0] addr);
        return int'((longint'(addr) - longint'(BASE)) / 4);
    endfunction

    function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (!ref_in_range(addr)) return;
        idx = ref_index(addr);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                ref_mem[idx][8*i +: 8] = data[8*i +: 8];
                ref_known[idx][i]      = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] addr);
        if (!ref_in_range(addr)) return 32'h0;
        return ref_mem[ref_index(addr)];
    endfunction

    function automatic logic [31:0] ref_mask(input logic [31:0] addr);
        logic [31:0] m = 32'h0;
        if (!ref_in_range(addr)) return 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (ref_known[ref_index(addr)][i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction: AW/W presented after their own delays, B held off b_hold cycles
    task automatic apply_stimulus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                        input int aw_dly, input int w_dly, input int b_hold, input string tag);
        bit          aw_done = 0;
        bit          w_done  = 0;
        int          cyc     = 0;
        logic [1:0]  exp_resp;
        exp_resp = ref_in_range(addr) ? 2'b10 ^ 2'b10 : 2'b10;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            @(negedge clk);
            check_output({tag, "_bvalid_idle"}, bvalid, 1'b0);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done  = 1;
            next_edge();
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_output({tag, "_accept"}, aw_done && w_done, 1'b1);
        @(negedge clk);
        check_output({tag, "_bvalid"}, bvalid, 1'b1);
        check_output({tag, "_bresp"}, bresp, exp_resp);
        ref_write(addr, data, strb);
        for (int h = 0; h < b_hold; h++) begin
            next_edge();
            awvalid = 1'b1;
            awaddr  = addr ^ 32'h4;
            wvalid  = 1'b1;
            wdata   = ~data;
            wstrb   = 4'hF;
            @(negedge clk);
            check_output({tag, "_hold_bvalid"}, bvalid, 1'b1);
            check_output({tag, "_hold_bresp"}, bresp, exp_resp);
            check_output({tag, "_hold_awready"}, awready, 1'b0);
            check_output({tag, "_hold_wready"}, wready, 1'b0);
        end
        next_edge();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        @(negedge clk);
        check_output({tag, "_bvalid_hs"}, bvalid, 1'b1);
        next_edge();
        bready = 1'b0;
        @(negedge clk);
        check_output({tag, "_bvalid_drop"}, bvalid, 1'b0);
        next_edge();
    endtask

    // Full read transaction with R held off r_hold cycles; rdata compared on known bytes
    task automatic apply_stimulus_read(input logic [31:0] addr, input int r_hold, input string tag,
                                       output logic [31:0] obs);
        bit          ar_done = 0;
        int          cyc     = 0;
        logic [1:0]  exp_resp;
        logic [31:0] mask;
        logic [31:0] exp_data;
        exp_resp = ref_in_range(addr) ? 2'b00 : 2'b10;
        mask     = ref_mask(addr);
        exp_data = ref_data(addr);
        while (!ar_done && cyc < 50) begin
            arvalid = 1'b1;
            araddr  = addr;
            @(negedge clk);
            if (arready) ar_done = 1;
            next_edge();
            cyc++;
        end
        arvalid = 1'b0;
        check_output({tag, "_accept"}, ar_done, 1'b1);
        @(negedge clk);
        obs = rdata;
        check_output({tag, "_rvalid"}, rvalid, 1'b1);
        check_output({tag, "_rresp"}, rresp, exp_resp);
        check_output({tag, "_rdata"}, rdata & mask, exp_data & mask);
        for (int h = 0; h < r_hold; h++) begin
            next_edge();
            arvalid = 1'b1;
            araddr  = addr ^ 32'h8;
            @(negedge clk);
            check_output({tag, "_hold_rvalid"}, rvalid, 1'b1);
            check_output({tag, "_hold_rresp"}, rresp, exp_resp);
            check_output({tag, "_hold_rdata"}, rdata, obs);
            check_output({tag, "_hold_arready"}, arready, 1'b0);
        end
        next_edge();
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        check_output({tag, "_rvalid_hs"}, rvalid, 1'b1);
        next_edge();
        rready = 1'b0;
        @(negedge clk);
        check_output({tag, "_rvalid_drop"}, rvalid, 1'b0);
        next_edge();
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] old_word;
        logic [31:0] r_addr, r_data;
        logic [3:0]  r_strb;

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = 32'h0;
            ref_known[i] = 4'h0;
        end
        arst_n  = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b000;
        wvalid  = 1'b0; wdata  = '0; wstrb  = 4'h0;
        bready  = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = 3'b000;
        rready  = 1'b0;

        $display("[TB] reset state");
        repeat (2) next_edge();
        @(negedge clk);
        check_output("rst_awready", awready, 1'b0);
        check_output("rst_wready", wready, 1'b0);
        check_output("rst_arready", arready, 1'b0);
        check_output("rst_bvalid", bvalid, 1'b0);
        check_output("rst_rvalid", rvalid, 1'b0);
        check_output("rst_bresp", bresp, 2'b00);
        check_output("rst_rresp", rresp, 2'b00);
        check_output("rst_rdata", rdata, 32'h0);
        next_edge();
        arst_n = 1'b1;
        @(negedge clk);
        check_output("rel0_readys", {awready, wready, arready}, 3'b000);
        check_output("rel0_valids", {bvalid, rvalid}, 2'b00);
        next_edge();
        @(negedge clk);
        check_output("rel1_readys", {awready, wready, arready}, 3'b111);
        check_output("rel1_valids", {bvalid, rvalid}, 2'b00);
        next_edge();

        $display("[TB] AW and W together");
        apply_stimulus_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, "wr_same");
        apply_stimulus_read(32'h10, 0, "rd_same", obs);
        check_output("rd_same_const", obs, 32'hDEADBEEF);

        $display("[TB] W before AW");
        apply_stimulus_write(32'h10, 32'h0000AA00, 4'h2, 2, 0, 0, "wr_wfirst");
        apply_stimulus_read(32'h10, 0, "rd_wfirst", obs);
        check_output("rd_wfirst_const", obs, 32'hDEADAAEF);

        $display("[TB] out of range");
        apply_stimulus_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 1, 0, "wr_word0");
        apply_stimulus_write(BASE + 4 * DEPTH, 32'h12345678, 4'hF, 0, 0, 0, "wr_oor");
        apply_stimulus_read(BASE + 4 * DEPTH, 0, "rd_oor", obs);
        check_output("rd_oor_const", obs, 32'h0);
        apply_stimulus_read(32'h0, 0, "rd_word0", obs);
        check_output("rd_word0_const", obs, 32'hCAFEF00D);

        $display("[TB] unaligned address and zero strobe");
        apply_stimulus_write(32'h13, 32'h55667788, 4'h1, 0, 0, 0, "wr_unal");
        apply_stimulus_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "wr_nostrb");
        apply_stimulus_read(32'h12, 0, "rd_unal", obs);
        check_output("rd_unal_const", obs, 32'hDEADAA88);

        $display("[TB] backpressure");
        apply_stimulus_write(32'h40, 32'hA5A55A5A, 4'hF, 0, 0, 5, "wr_bp");
        apply_stimulus_read(32'h40, 5, "rd_bp", obs);

        $display("[TB] read/write collision");
        old_word = ref_data(32'h10);
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h01020304; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h10;
        @(negedge clk);
        check_output("col_readys", {awready, wready, arready}, 3'b111);
        next_edge();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check_output("col_valids", {bvalid, rvalid}, 2'b11);
        check_output("col_rdata_old", rdata, old_word);
        check_output("col_bresp", bresp, 2'b00);
        ref_write(32'h10, 32'h01020304, 4'hF);
        next_edge();
        bready = 1'b1; rready = 1'b1;
        next_edge();
        bready = 1'b0; rready = 1'b0;
        apply_stimulus_read(32'h10, 0, "rd_col_after", obs);

        $display("[TB] reset during write");
        apply_stimulus_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0, "wr_prerst");
        awvalid = 1'b1; awaddr = 32'h20;
        @(negedge clk);
        check_output("mid_aw_accept", awready, 1'b1);
        next_edge();
        awvalid = 1'b0;
        wvalid  = 1'b1; wdata = 32'hBADBAD00; wstrb = 4'hF;
        arst_n  = 1'b0;
        @(negedge clk);
        check_output("mid_rst_readys", {awready, wready, arready}, 3'b000);
        check_output("mid_rst_bvalid", bvalid, 1'b0);
        next_edge();
        wvalid = 1'b0;
        arst_n = 1'b1;
        @(negedge clk);
        check_output("mid_rel0_readys", {awready, wready, arready}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            next_edge();
            @(negedge clk);
            check_output("mid_idle_readys", {awready, wready, arready}, 3'b111);
            check_output("mid_no_bvalid", bvalid, 1'b0);
        end
        next_edge();
        apply_stimulus_read(32'h20, 0, "rd_after_rst", obs);
        check_output("rd_after_rst_const", obs, 32'h11223344);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9) == 0) begin
                r_addr = BASE + 4 * DEPTH + 4 * $urandom_range(15);
            end else begin
                r_addr = BASE + 4 * $urandom_range(DEPTH - 1) + $urandom_range(3);
            end
            r_data = $urandom;
            r_strb = 4'($urandom_range(15));
            apply_stimulus_write(r_addr, r_data, r_strb, $urandom_range(2), $urandom_range(2),
                                 $urandom_range(2), "rnd_wr");
            apply_stimulus_read(r_addr, $urandom_range(2), "rnd_rd", obs);
            apply_stimulus_read(BASE + 4 * $urandom_range(DEPTH - 1), 0, "rnd_rd_any", obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
